// File: rtl/verdict_pkg.sv
// verdict_collector shared types
// stream widths, snapshot bundle, serializer states
package verdict_pkg;

  localparam int NUM_OUT = 3;
  localparam int DATA_W  = 64;
  localparam int TS_W    = 32;
  localparam int ID_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef struct packed {
    logic [NUM_OUT-1:0]        aktv;
    logic [NUM_OUT*DATA_W-1:0] vals;
    logic [TS_W-1:0]           ts;
  } snap_t;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // index of the lowest set bit (0 when none)
  function automatic logic [ID_W-1:0] lsb_idx(
    input logic [NUM_OUT-1:0] m
  );
    lsb_idx = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (m[i]) lsb_idx = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// snapshot FIFO for verdict_collector
// a pop loads the head into registered read data
module verdict_fifo
  import verdict_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  snap_t                  i_wdata,
  input  logic                   i_pop,
  output snap_t                  o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  snap_t         r_mem [DEPTH];
  snap_t         r_rdata;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_do_pop;
  logic          w_do_push;

  // a full FIFO still takes a write when the head leaves on the same edge
  assign w_do_pop  = i_pop && (r_cnt != '0);
  assign w_do_push = i_push && ((r_cnt != FULL_CNT) || w_do_pop);

  assign o_rdata = r_rdata;
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  // storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

  // pointers, occupancy and read data register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop) begin
        r_rd    <= r_rd + 1'b1;
        r_rdata <= r_mem[r_rd];
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/verdict_collector.sv
// verdict_collector: timestamps monitor outputs
// and streams (id, value, ts) words on valid/ready
module verdict_collector #(
  parameter int NUM_OUT = verdict_pkg::NUM_OUT,
  parameter int DATA_W  = verdict_pkg::DATA_W,
  parameter int TS_W    = verdict_pkg::TS_W,
  parameter int DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_OUT*DATA_W-1:0]   out_val,
  input  logic [NUM_OUT-1:0]          out_aktv,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [verdict_pkg::ID_W-1:0] m_id,
  output logic [DATA_W-1:0]           m_value,
  output logic [TS_W-1:0]             m_ts,
  output logic                        m_last,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt
);

  import verdict_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [TS_W-1:0]  r_ts;
  logic             r_ovf;
  logic [15:0]      r_drop;
  logic [NUM_OUT-1:0] r_done;

  snap_t            w_wdata;
  snap_t            w_head;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_pop;
  logic             w_cap;
  logic             w_push;
  logic             w_drop;
  logic             w_hs;
  logic             w_last;
  logic [NUM_OUT-1:0] w_rem;
  logic [NUM_OUT-1:0] w_bit;
  logic [ID_W-1:0]  w_id;

  verdict_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // snapshot assembly and admission
  always_comb begin
    w_wdata      = '0;
    w_wdata.aktv = out_aktv;
    w_wdata.vals = out_val;
    w_wdata.ts   = r_ts;
    w_cap  = en && (|out_aktv);
    w_push = w_cap && (!w_full || w_pop);
    w_drop = w_cap && !w_push;
  end

  // remaining streams of the working snapshot
  always_comb begin
    w_rem  = w_head.aktv & ~r_done;
    w_bit  = w_rem & (~w_rem + 1'b1);
    w_id   = lsb_idx(w_rem);
    w_last = ((w_rem & ~w_bit) == '0);
  end

  // serial port view, zeroed while idle
  always_comb begin
    m_valid = (r_state == EMIT);
    w_hs    = m_valid && m_ready;
    m_id    = '0;
    m_value = '0;
    m_ts    = '0;
    m_last  = 1'b0;
    if (m_valid) begin
      m_id    = w_id;
      m_value = w_head.vals[w_id*DATA_W +: DATA_W];
      m_ts    = w_head.ts;
      m_last  = w_last;
    end
  end

  // next state and pop request
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = EMIT;
        end
      end
      EMIT: begin
        if (w_hs && w_last) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_next = IDLE;
        end
      end
    endcase
  end

  // serializer state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // streams already emitted from the working snapshot
  always_ff @(posedge clk) begin
    if (rst)        r_done <= '0;
    else if (w_pop) r_done <= '0;
    else if (w_hs)  r_done <= r_done | w_bit;
  end

  // free-running capture timestamp
  always_ff @(posedge clk) begin
    if (rst)     r_ts <= '0;
    else if (en) r_ts <= r_ts + 1'b1;
  end

  // sticky overflow and saturating drop count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end
  end

  assign overflow = r_ovf;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_verdict_collector.sv
// verdict_collector bench: queue-based reference
// model feeding a scoreboard checked by a monitor
module tb_verdict_collector;

  localparam int NO    = 3;
  localparam int DW    = 64;
  localparam int TW    = 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NO*DW-1:0] out_val;
  logic [NO-1:0]   out_aktv;
  logic            m_valid;
  logic            m_ready;
  logic [1:0]      m_id;
  logic [DW-1:0]   m_value;
  logic [TW-1:0]   m_ts;
  logic            m_last;
  logic            overflow;
  logic [15:0]     drop_cnt;

  verdict_collector #(
    .NUM_OUT (NO),
    .DATA_W  (DW),
    .TS_W    (TW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .out_val  (out_val),
    .out_aktv (out_aktv),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_id     (m_id),
    .m_value  (m_value),
    .m_ts     (m_ts),
    .m_last   (m_last),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] val;
    logic [31:0] ts;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          snap_q[$];
  int          wrem = 0;
  logic [31:0] mts  = '0;
  int          mdrop = 0;
  logic        movf = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // reference model: snapshot queue plus words left in the working one
  bit    hs, pop, cap, acc;
  int    k, n;
  word_t w;
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      snap_q.delete();
      wrem  = 0;
      mts   = '0;
      mdrop = 0;
      movf  = 1'b0;
    end else begin
      hs  = (wrem > 0) && m_ready;
      pop = 1'b0;
      if (wrem == 0) pop = (snap_q.size() > 0);
      else if (hs) begin
        if (wrem == 1) pop = (snap_q.size() > 0);
        wrem--;
      end
      cap = en && (|out_aktv);
      acc = cap && ((snap_q.size() < DEPTH) || pop);
      if (pop) wrem = snap_q.pop_front();
      if (acc) begin
        k = 0;
        for (int i = 0; i < NO; i++) if (out_aktv[i]) k++;
        n = 0;
        for (int i = 0; i < NO; i++) begin
          if (out_aktv[i]) begin
            n++;
            w.id   = i;
            w.val  = out_val[i*DW +: DW];
            w.ts   = mts;
            w.last = (n == k);
            exp_q.push_back(w);
          end
        end
        snap_q.push_back(k);
      end else if (cap) begin
        movf = 1'b1;
        if (mdrop < 65535) mdrop++;
      end
      if (en) mts = mts + 1;
    end
  end

  // monitor: compare presented words against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 64'(m_valid), 64'(wrem > 0));
      chk("status", 64'({overflow, drop_cnt}), 64'({movf, 16'(mdrop)}));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: got id %0d with none required", m_id);
        end else begin
          chk("m_id", 64'(m_id), 64'(exp_q[0].id));
          chk("m_value", m_value, exp_q[0].val);
          chk("m_ts", 64'(m_ts), 64'(exp_q[0].ts));
          chk("m_last", 64'(m_last), 64'(exp_q[0].last));
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    m_ready  = 1'b1;
    out_aktv = '0;
    while ((exp_q.size() != 0 || wrem != 0) && c < 300) begin
      step();
      c++;
    end
    checks++;
    if (c >= 300) begin
      errors++;
      $display("FAIL drain: got %0d words left required 0", exp_q.size());
    end
  endtask

  task automatic put(input logic [NO-1:0] a, input logic [63:0] v0,
                     input logic [63:0] v1, input logic [63:0] v2);
    en       = 1'b1;
    out_aktv = a;
    out_val  = {v2, v1, v0};
    step();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    out_aktv = '0;
    out_val = '0;
    m_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_id", 64'(m_id), 64'd0);
    chk("rst_value", m_value, 64'd0);
    chk("rst_ts", 64'(m_ts), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // single snapshot at ts 5, streams d and f
    m_ready = 1'b1;
    en = 1'b1;
    repeat (5) step();
    put(3'b101, 64'd1, 64'd99, 64'd7);
    out_aktv = '0;
    chk("lat_e0", 64'(m_valid), 64'd0);
    step();
    chk("lat_e1", 64'(m_valid), 64'd1);
    chk("lat_ts", 64'(m_ts), 64'd5);
    drain();

    // backpressure on the first word
    m_ready = 1'b0;
    put(3'b011, 64'hA5A5, 64'h5A5A, 64'd0);
    out_aktv = '0;
    repeat (5) step();
    m_ready = 1'b1;
    drain();

    // burst of five full snapshots
    for (int x = 1; x <= 5; x++)
      put(3'b111, 64'(x), 64'(10 * x), 64'(100 * x));
    drain();

    // overflow: one snapshot parked in the serializer, then ten more
    m_ready = 1'b0;
    put(3'b001, 64'd42, 64'd0, 64'd0);
    out_aktv = '0;
    repeat (2) step();
    for (int x = 0; x < 10; x++)
      put(3'b010, 64'd0, 64'(x + 200), 64'd0);
    out_aktv = '0;
    step();
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);

    // full FIFO: last-word handshake coincides with a capture
    m_ready = 1'b1;
    put(3'b100, 64'd0, 64'd0, 64'd77);
    out_aktv = '0;
    chk("full_pop_drop", 64'(drop_cnt), 64'd2);
    drain();

    // reset while a word is on the port with snapshots queued
    m_ready = 1'b0;
    for (int x = 0; x < 4; x++)
      put(3'b110, 64'd0, 64'(x), 64'(x + 1));
    out_aktv = '0;
    step();
    chk("pre_rst_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    put(3'b001, 64'd9, 64'd0, 64'd0);
    out_aktv = '0;
    step();
    chk("post_rst_valid", 64'(m_valid), 64'd1);
    chk("post_rst_ts", 64'(m_ts), 64'd0);
    drain();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      out_aktv = NO'($urandom);
      out_val  = {$urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom};
      m_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Output-side counterpart to the stimulus driver of the generated RTLola monitor (`topEntity`). It samples the monitor's output stream values and their `_aktv` flags every enabled cycle, timestamps each non-empty snapshot, and buffers snapshots in a FIFO. It then serialises them as one (stream id, value, timestamp) word per active stream on a valid/ready port. It sits between the monitor and the host/trace sink, replacing waveform inspection of `output_*` wires.

## Interface
- `NUM_OUT`, default 3: number of monitor output streams (d, e, f → ids 0, 1, 2).
- `DATA_W`, default 64: width of each signed stream value.
- `TS_W`, default 32: timestamp counter width.
- `DEPTH`, default 8: snapshot FIFO depth; power of two, ≥ 2.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: capture/timestamp enable (same `en` as the monitor).
- `out_val`  in  NUM_OUT*DATA_W: stream values; stream i is at bits [i*DATA_W +: DATA_W].
- `out_aktv`  in  NUM_OUT: per-stream active flags.
- `m_valid`  out  1: serial word valid.
- `m_ready`  in  1: sink accepts the word.
- `m_id`  out  $clog2(NUM_OUT): stream index of the word.
- `m_value`  out  DATA_W: stream value.
- `m_ts`  out  TS_W: capture timestamp.
- `m_last`  out  1: last word of its snapshot.
- `overflow`  out  1: sticky; a snapshot was dropped.
- `drop_cnt`  out  16: saturating count of dropped snapshots.

## Operation
- Timestamp counter `ts`: resets to 0; increments by 1 on every edge with `en=1`; wraps modulo 2^TS_W; holds while `en=0`.
- Capture: on an edge with `en=1` and `|out_aktv`, write {out_aktv, out_val, ts} to the FIFO. Values of inactive streams are stored but never emitted. Nothing is captured when `en=0` or `out_aktv=0`.
- Full: the write is accepted if count < DEPTH, or if count = DEPTH and a pop occurs on the same edge. Otherwise the snapshot is dropped, `overflow` is set, and `drop_cnt` increments, saturating at 0xFFFF.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, pop into the working register and go to EMIT.
  - EMIT: present the lowest set bit of the remaining mask. On `m_valid && m_ready`, clear that bit. If it was the last bit (`m_last=1`), pop the next snapshot when the FIFO is non-empty and stay in EMIT; otherwise return to IDLE.
- Output stability: while `m_valid=1` and `m_ready=0`, all `m_*` outputs hold stable. `m_valid` never drops without a handshake.
- Reset values: `m_valid`, `m_id`, `m_value`, `m_ts`, `m_last`, `overflow`, `drop_cnt`, `ts`, and the FIFO count are all 0; FSM is in IDLE.
- Reset mid-operation discards the FIFO contents and the in-flight snapshot; `m_valid` is 0 in the cycle after the reset edge.
- `en=0` stops capture only; draining continues.

## Timing
- Latency: `out_aktv` sampled at edge E0 → FIFO entry at E0 → popped at E1 → `m_valid=1` after E1 (two cycles, empty FIFO, idle FSM).
- Throughput: one word per cycle with `m_ready` held high. There is no bubble between snapshots when the FIFO is non-empty at the `m_last` handshake.
- A snapshot with k active streams occupies k consecutive handshakes, ids ascending, all carrying the same `m_ts`.
- FIFO count changes by +1, −1, or 0 (simultaneous push and pop) per edge.

## Structure
- Package `verdict_pkg`: holds `NUM_OUT`, `DATA_W`, `TS_W`, `ID_W`, the snapshot struct {aktv, vals, ts}, and the FSM state enum {IDLE, EMIT}.
- Sub-module `verdict_fifo`: synchronous FIFO of snapshot structs, parameterised by DEPTH, with push/pop/full/empty/count and registered read data. The serializer, timestamp counter, and overflow logic live in the top module.

## Test plan
- Single snapshot: `rst` low, `ts`=5, `out_aktv`=3'b101, d=1, f=7, `m_ready`=1 → two words: (id0, 1, ts5, last0), then (id2, 7, ts5, last1). The first `m_valid` appears two cycles after capture.
- Backpressure: `m_ready`=0 for 4 cycles during the first word → `m_*` stable throughout; the word is then accepted on the first `m_ready`=1 cycle.
- Burst matching the stimulus pattern: x=1..5 on consecutive cycles, all streams active, `m_ready`=1 → 15 words, ts ascending by 1, with no gaps between snapshots.
- Overflow: `m_ready`=0, 10 consecutive active snapshots, DEPTH=8 → 8 stored, `overflow`=1, `drop_cnt`=2; draining yields ts values of the first 8 only.
- Full with simultaneous pop: FIFO holds 8 snapshots, and the `m_last` handshake of one coincides with a new capture → the capture is accepted, `drop_cnt` is unchanged, and count stays 8.
- Reset mid-operation: assert `rst` for 1 cycle while `m_valid`=1 with 3 snapshots queued → `m_valid`=0 next cycle; FIFO empty; `ts`, `overflow`, and `drop_cnt` are 0. A new capture after reset carries ts 0.
